// File: rtl/ysyx_23060236_lsu.sv
// Memory-access stage: one instruction in flight, optional load/store over a simplified AXI4-Lite master.
// Optional misaligned-access trap: define YSYX_23060236_LSU_MISALIGN_CHECK_EN.
module ysyx_23060236_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lsu_in_valid,
  input  logic              lsu_ren,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] val,
  input  logic [DATA_W-1:0] src2,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic              reg_wen,
  output logic              lsu_over,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_wen,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
`ifdef YSYX_23060236_LSU_MISALIGN_CHECK_EN
  ,
  output logic              lsu_misalign
`endif
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, BRESP, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              wen_q;
  logic              aw_done, w_done;
  logic              mis_in;
  logic [3:0]        strb_in;
  logic [DATA_W-1:0] ld_word, ld_data;
  logic              unused_resp;

  assign unused_resp = ^{rresp, bresp};

`ifdef YSYX_23060236_LSU_MISALIGN_CHECK_EN
  logic mis_q;
  assign mis_in = (lsu_ren | lsu_wen) &
                  (((funct3[1:0] == 2'b01) & val[0]) | ((funct3[1:0] == 2'b10) & (|val[1:0])));
`else
  assign mis_in = 1'b0;
`endif

  always_comb begin
    case (funct3)
      3'b000:  strb_in = 4'b0001 << val[1:0];
      3'b001:  strb_in = 4'b0011 << val[1:0];
      default: strb_in = 4'b1111;
    endcase
  end

  // Load data: bring the addressed byte lane down to bit 0, then extend.
  assign ld_word = rdata >> {addr_q[1:0], 3'b000};
  always_comb begin
    case (f3_q)
      3'b000:  ld_data = {{(DATA_W-8){ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_data = {{(DATA_W-16){ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_data = {{(DATA_W-8){1'b0}}, ld_word[7:0]};
      3'b101:  ld_data = {{(DATA_W-16){1'b0}}, ld_word[15:0]};
      default: ld_data = ld_word;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (lsu_in_valid) begin
        if (mis_in)       state_nxt = DONE;
        else if (lsu_ren) state_nxt = RADDR;
        else if (lsu_wen) state_nxt = WRITE;
        else              state_nxt = DONE;
      end
      RADDR: if (arready) state_nxt = RDATA;
      RDATA: if (rvalid)  state_nxt = DONE;
      WRITE: if ((aw_done | awready) & (w_done | wready)) state_nxt = BRESP;
      BRESP: if (bvalid)  state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    arvalid  = (state == RADDR);
    rready   = (state == RDATA);
    awvalid  = (state == WRITE) & ~aw_done;
    wvalid   = (state == WRITE) & ~w_done;
    bready   = (state == BRESP);
    lsu_over = (state == DONE);
    wb_valid = (state == DONE);
`ifdef YSYX_23060236_LSU_MISALIGN_CHECK_EN
    lsu_misalign = (state == DONE) & mis_q;
`endif
  end

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      wb_rd   <= '0;
      wb_wen  <= 1'b0;
      wb_data <= '0;
`ifdef YSYX_23060236_LSU_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (lsu_in_valid) begin
          addr_q  <= val;
          wdata_q <= src2 << {val[1:0], 3'b000};
          wstrb_q <= strb_in;
          f3_q    <= funct3;
          rd_q    <= rd;
          wen_q   <= reg_wen;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
`ifdef YSYX_23060236_LSU_MISALIGN_CHECK_EN
          mis_q   <= mis_in;
`endif
          // Ops that skip the bus publish their record straight away.
          if (mis_in | ~(lsu_ren | lsu_wen)) begin
            wb_rd   <= rd;
            wb_wen  <= reg_wen & ~mis_in;
            wb_data <= val;
          end
        end
        RDATA: if (rvalid) begin
          wb_rd   <= rd_q;
          wb_wen  <= wen_q;
          wb_data <= ld_data;
        end
        WRITE: begin
          if (awvalid & awready) aw_done <= 1'b1;
          if (wvalid & wready)   w_done  <= 1'b1;
        end
        BRESP: if (bvalid) begin
          wb_rd   <= rd_q;
          wb_wen  <= 1'b0;
          wb_data <= addr_q;
        end
        default: ;
      endcase
    end
  end

endmodule
